pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
// - Fetch sequencer around the PC datapath: owns the program counter and drives instruction-memory requests.
// - Applies branch redirects (target = branch PC + immediate) and buffers one fetched instruction for decode.
// - Sits between the PC register and decode: imem handshake upstream, valid/ready handshake downstream.
// - Also handles stall, in-flight flush and a memory-timeout fault.
// PARAMETERS
// - D_WIDTH   32   address/data width (bits)
// - RESET_PC  0    PC loaded on reset
// - TIMEOUT   16   max cycles waiting for imem_ack before fault (>=2)
// PORTS
// - clk            in   1        clock; all state updates on rising edge
// - rst            in   1        reset, synchronous, active-low (rst==0 on a rising edge resets)
// - stall          in   1        hazard stall from core; freezes hand-off to decode
// - PCsrc          in   1        branch taken: redirect fetch this cycle
// - br_pc          in   D_WIDTH  PC of branching instruction
// - ImmOp          in   D_WIDTH  sign-extended branch offset
// - imem_req       out  1        fetch request valid
// - imem_addr      out  D_WIDTH  fetch address; stable while imem_req==1
// - imem_ack       in   1        memory returns imem_rdata this cycle
// - imem_rdata     in   D_WIDTH  fetched instruction word
// - inst_valid     out  1        inst_out/inst_pc valid for decode
// - inst_out       out  D_WIDTH  buffered instruction
// - inst_pc        out  D_WIDTH  address of inst_out
// - inst_ready     in   1        decode accepts inst_out
// - fault          out  1        sticky fault flag
// BEHAVIOUR
// - Reset: PC=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, fault=0, timeout count=0.
// - Target = br_pc + ImmOp mod 2^D_WIDTH; sequential next = PC + 4 mod 2^D_WIDTH (wraps 0xFFFFFFFC -> 0x0).
// - Registered outputs; imem_addr = PC.
// - IDLE: imem_req=0. If !stall -> REQ. PCsrc in IDLE loads PC=target.
// - REQ: imem_req=1, addr held until ack.
//   - ack & !PCsrc: inst_out=rdata, inst_pc=PC, inst_valid=1, PC+=4 -> HOLD.
//   - ack & PCsrc: discard rdata, PC=target, stay REQ (new addr next cycle).
//   - !ack & PCsrc: save target -> FLUSH.
// - FLUSH: imem_req=1 with old addr (no mid-transaction address change).
//   - New PCsrc overwrites saved target (latest wins).
//   - On ack: discard rdata, PC=saved/latest target -> REQ.
// - HOLD: imem_req=0, inst_valid=1.
//   - inst_ready & !stall & !PCsrc: inst_valid=0 next cycle -> REQ.
//   - PCsrc (priority over inst_ready): inst_valid=0, PC=target -> REQ.
//   - stall or !inst_ready: outputs frozen.
// - Throughput: one instruction per 2 cycles with 1-cycle memory; request-to-inst_valid latency = ack cycle + 1.
// - Timeout: counter runs in REQ/FLUSH, clears on ack. TIMEOUT cycles without ack -> fault=1, ERROR.
// - ERROR: imem_req=0, inst_valid=0, PC frozen; left only by reset.
// - stall never aborts an in-flight request. Reset mid-request drops it immediately (imem_req=0 next cycle).
// - imem_ack outside REQ/FLUSH is ignored.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined: target[1:0]!=0 on PCsrc -> fault=1, ERROR next cycle; no fetch issued to misaligned address.
// - MISALIGN_TRAP_EN undefined: target[1:0] forced to 2'b00; fault driven only by timeout.
// TESTING
// - Reset, 1-cycle ack, inst_ready=1 -> imem_addr sequence 0x0,0x4,0x8; inst_pc matches; inst_valid 1 cycle after each ack.
// - PCsrc in HOLD, br_pc=0x10, ImmOp=0xFFFFFFF8 -> inst_valid drops; next imem_addr=0x8.
// - PCsrc in REQ, ack 3 cycles later, br_pc=0x20, ImmOp=0x40 -> addr stays old until ack; rdata discarded; next addr=0x60, inst_valid stays 0.
// - stall=1 for 5 cycles in HOLD -> inst_out/inst_pc/inst_valid unchanged, no new imem_req.
// - Withhold ack for TIMEOUT cycles -> fault=1, imem_req=0; stays so until rst=0 -> PC=RESET_PC, fault=0.
// - With MISALIGN_TRAP_EN, br_pc=0x0, ImmOp=0x6 -> fault=1, no request to 0x6. Without it -> next imem_addr=0x4.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Fetch sequencer that owns the program counter, issues instruction-memory
//   requests, applies branch redirects (target = br_pc + ImmOp) and buffers
//   one fetched instruction for decode. A request that never sees imem_ack
//   within TIMEOUT cycles raises a sticky fault.
//
// Parameters
//   D_WIDTH   address/data width
//   RESET_PC  PC loaded on reset
//   TIMEOUT   cycles a request may wait for imem_ack before faulting (>=2)
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   stall             core hazard stall, freezes the hand-off to decode
//   PCsrc, br_pc,     branch taken, branch PC and sign-extended offset
//   ImmOp
//   imem_req/addr     fetch request and its address (address = PC)
//   imem_ack/rdata    memory response
//   inst_valid/out/pc buffered instruction for decode
//   inst_ready        decode accepts the buffered instruction
//   fault             sticky fault flag
//
// Build option
//   MISALIGN_TRAP_EN  when defined, a taken branch to a target with
//                     target[1:0] != 0 faults instead of fetching. When
//                     undefined, the low two target bits are cleared.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | after reset, no request; leaves when stall is low
// S_REQ   | request outstanding at PC, waiting for imem_ack
// S_FLUSH | redirect arrived mid-request; finish old request, then discard
// S_HOLD  | instruction buffered, waiting for decode to accept it
// S_ERROR | timeout or misaligned target; only reset leaves this state

module pc_fetch_ctrl #(
    parameter int                 D_WIDTH  = 32,
    parameter logic [D_WIDTH-1:0] RESET_PC = '0,
    parameter int                 TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               PCsrc,
    input  logic [D_WIDTH-1:0] br_pc,
    input  logic [D_WIDTH-1:0] ImmOp,
    output logic               imem_req,
    output logic [D_WIDTH-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [D_WIDTH-1:0] imem_rdata,
    output logic               inst_valid,
    output logic [D_WIDTH-1:0] inst_out,
    output logic [D_WIDTH-1:0] inst_pc,
    input  logic               inst_ready,
    output logic               fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_FLUSH = 3'd2,
        S_HOLD  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam int                 CNT_W      = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]   TMR_LOAD   = CNT_W'(TIMEOUT - 1);
    localparam logic [D_WIDTH-1:0] ALIGN_MASK = {{(D_WIDTH-2){1'b1}}, 2'b00};

    state_t             state;
    logic [D_WIDTH-1:0] pc;
    logic [D_WIDTH-1:0] saved_tgt;
    logic [CNT_W-1:0]   tmr;

    logic [D_WIDTH-1:0] target_raw;
    logic [D_WIDTH-1:0] target;
    logic               trap_hit;

    assign target_raw = br_pc + ImmOp;
    assign target     = target_raw & ALIGN_MASK;

`ifdef MISALIGN_TRAP_EN
    assign trap_hit = PCsrc && (target_raw[1:0] != 2'b00);
`else
    assign trap_hit = 1'b0;
`endif

    assign imem_addr = pc;

    // tmr is a down-counter: loaded with TIMEOUT-1 whenever a request
    // starts or is acknowledged, and a miss while it sits at zero is the
    // TIMEOUT-th cycle without an ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            saved_tgt  <= '0;
            tmr        <= '0;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            inst_pc    <= '0;
            fault      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trap_hit) begin
                        state    <= S_ERROR;
                        fault    <= 1'b1;
                        imem_req <= 1'b0;
                    end else begin
                        if (PCsrc) pc <= target;
                        if (!stall) begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                            tmr      <= TMR_LOAD;
                        end
                    end
                end

                S_REQ: begin
                    if (trap_hit) begin
                        state    <= S_ERROR;
                        fault    <= 1'b1;
                        imem_req <= 1'b0;
                    end else if (imem_ack) begin
                        tmr <= TMR_LOAD;
                        if (PCsrc) begin
                            // redirect coincides with the response: drop it
                            // and re-request at the target next cycle
                            pc <= target;
                        end else begin
                            inst_out   <= imem_rdata;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc + D_WIDTH'(4);
                            imem_req   <= 1'b0;
                            state      <= S_HOLD;
                        end
                    end else if (tmr == '0) begin
                        state    <= S_ERROR;
                        fault    <= 1'b1;
                        imem_req <= 1'b0;
                    end else begin
                        tmr <= tmr - CNT_W'(1);
                        if (PCsrc) begin
                            // address must stay stable until the ack, so
                            // park the target and let the old fetch finish
                            saved_tgt <= target;
                            state     <= S_FLUSH;
                        end
                    end
                end

                S_FLUSH: begin
                    if (trap_hit) begin
                        state    <= S_ERROR;
                        fault    <= 1'b1;
                        imem_req <= 1'b0;
                    end else if (imem_ack) begin
                        tmr   <= TMR_LOAD;
                        pc    <= PCsrc ? target : saved_tgt;
                        state <= S_REQ;
                    end else if (tmr == '0) begin
                        state    <= S_ERROR;
                        fault    <= 1'b1;
                        imem_req <= 1'b0;
                    end else begin
                        tmr <= tmr - CNT_W'(1);
                        if (PCsrc) saved_tgt <= target;
                    end
                end

                S_HOLD: begin
                    if (trap_hit) begin
                        state      <= S_ERROR;
                        fault      <= 1'b1;
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b0;
                    end else if (PCsrc) begin
                        // a taken branch squashes the buffered instruction
                        // even while decode is stalled
                        inst_valid <= 1'b0;
                        pc         <= target;
                        imem_req   <= 1'b1;
                        tmr        <= TMR_LOAD;
                        state      <= S_REQ;
                    end else if (inst_ready && !stall) begin
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        tmr        <= TMR_LOAD;
                        state      <= S_REQ;
                    end
                end

                S_ERROR: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end

                default: begin
                    state      <= S_ERROR;
                    fault      <= 1'b1;
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level reference model.

module tb_pc_fetch_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        PCsrc = 1'b0;
    logic [31:0] br_pc = '0;
    logic [31:0] ImmOp = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        fault;

    int checks = 0;
    int errors = 0;

    // reference model: what fetch has done, not how the RTL sequences it
    logic [31:0] m_pc, m_out, m_ipc, m_saved;
    logic        m_req, m_valid, m_fault, m_started, m_flush;
    int          m_miss;

    pc_fetch_ctrl #(
        .D_WIDTH (32),
        .RESET_PC(32'h0),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .PCsrc     (PCsrc),
        .br_pc     (br_pc),
        .ImmOp     (ImmOp),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst_out  (inst_out),
        .inst_pc   (inst_pc),
        .inst_ready(inst_ready),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [31:0] tgt_raw;
        logic [31:0] tgt;
        tgt_raw = br_pc + ImmOp;
        tgt     = {tgt_raw[31:2], 2'b00};
        if (!rst) begin
            m_pc = 32'h0; m_out = '0; m_ipc = '0; m_saved = '0;
            m_req = 0; m_valid = 0; m_fault = 0; m_started = 0; m_flush = 0;
            m_miss = 0;
            return;
        end
        if (m_fault) return;
`ifdef MISALIGN_TRAP_EN
        if (PCsrc && tgt_raw[1:0] != 2'b00) begin
            m_fault = 1; m_req = 0; m_valid = 0;
            return;
        end
`endif
        if (!m_started) begin
            if (PCsrc) m_pc = tgt;
            if (!stall) begin
                m_started = 1; m_req = 1; m_miss = 0;
            end
        end else if (m_req) begin
            if (imem_ack) begin
                m_miss = 0;
                if (m_flush) begin
                    m_pc    = PCsrc ? tgt : m_saved;
                    m_flush = 0;
                end else if (PCsrc) begin
                    m_pc = tgt;
                end else begin
                    m_out = imem_rdata; m_ipc = m_pc; m_valid = 1;
                    m_pc  = m_pc + 32'd4; m_req = 0;
                end
            end else begin
                m_miss++;
                if (PCsrc) begin
                    m_flush = 1; m_saved = tgt;
                end
                if (m_miss == TIMEOUT) begin
                    m_fault = 1; m_req = 0; m_flush = 0;
                end
            end
        end else if (m_valid) begin
            if (PCsrc) begin
                m_valid = 0; m_pc = tgt; m_req = 1; m_miss = 0;
            end else if (inst_ready && !stall) begin
                m_valid = 0; m_req = 1; m_miss = 0;
            end
        end
    endtask

    // one clock: model follows the same edge, outputs compared 1 time unit later
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
        chk("fault", {31'b0, fault}, {31'b0, m_fault});
        if (m_valid) begin
            chk("inst_out", inst_out, m_out);
            chk("inst_pc", inst_pc, m_ipc);
        end
    endtask

    int drought;

    initial begin
        // reset
        rst = 1'b0;
        cycle();
        cycle();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_out", inst_out, 32'h0);
        chk("rst_ipc", inst_pc, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'd0);

        // sequential fetch with single-cycle memory
        rst = 1'b1; inst_ready = 1'b1;
        cycle();
        for (int n = 0; n < 3; n++) begin
            chk("seq_addr", imem_addr, 32'(n * 4));
            chk("seq_req", {31'b0, imem_req}, 32'd1);
            imem_ack = 1'b1; imem_rdata = 32'hA000_0000 + 32'(n);
            cycle();
            chk("seq_valid", {31'b0, inst_valid}, 32'd1);
            chk("seq_ipc", inst_pc, 32'(n * 4));
            chk("seq_out", inst_out, 32'hA000_0000 + 32'(n));
            imem_ack = 1'b0;
            if (n < 2) cycle();
        end

        // branch while holding an instruction
        PCsrc = 1'b1; br_pc = 32'h10; ImmOp = 32'hFFFF_FFF8;
        cycle();
        PCsrc = 1'b0;
        chk("hold_br_valid", {31'b0, inst_valid}, 32'd0);
        chk("hold_br_addr", imem_addr, 32'h8);

        // branch during an outstanding request, ack three cycles later
        PCsrc = 1'b1; br_pc = 32'h20; ImmOp = 32'h40;
        cycle();
        PCsrc = 1'b0;
        chk("flush_addr0", imem_addr, 32'h8);
        cycle();
        chk("flush_addr1", imem_addr, 32'h8);
        cycle();
        chk("flush_addr2", imem_addr, 32'h8);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cycle();
        imem_ack = 1'b0;
        chk("flush_new_addr", imem_addr, 32'h60);
        chk("flush_valid", {31'b0, inst_valid}, 32'd0);
        chk("flush_req", {31'b0, imem_req}, 32'd1);

        // stall while holding
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        cycle();
        imem_ack = 1'b0; stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_valid", {31'b0, inst_valid}, 32'd1);
            chk("stall_ipc", inst_pc, 32'h60);
            chk("stall_out", inst_out, 32'h1234_5678);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        cycle();
        chk("unstall_addr", imem_addr, 32'h64);

        // memory timeout
        for (int i = 1; i <= TIMEOUT; i++) begin
            cycle();
            chk("to_fault", {31'b0, fault}, {31'b0, (i == TIMEOUT)});
            chk("to_req", {31'b0, imem_req}, {31'b0, (i != TIMEOUT)});
        end
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("err_fault", {31'b0, fault}, 32'd1);
            chk("err_req", {31'b0, imem_req}, 32'd0);
        end
        imem_ack = 1'b0; rst = 1'b0;
        cycle();
        chk("err_rst_fault", {31'b0, fault}, 32'd0);
        chk("err_rst_addr", imem_addr, 32'h0);
        rst = 1'b1;

        // misaligned branch target from IDLE
        PCsrc = 1'b1; br_pc = 32'h0; ImmOp = 32'h6;
        cycle();
        PCsrc = 1'b0;
`ifdef MISALIGN_TRAP_EN
        chk("mis_fault", {31'b0, fault}, 32'd1);
        chk("mis_req", {31'b0, imem_req}, 32'd0);
`else
        chk("mis_addr", imem_addr, 32'h4);
        chk("mis_req", {31'b0, imem_req}, 32'd1);
`endif
        rst = 1'b0;
        cycle();
        rst = 1'b1;

        // randomized traffic
        drought = 0;
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 299) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            inst_ready = ($urandom_range(0, 3) != 0);
            PCsrc      = ($urandom_range(0, 7) == 0);
            br_pc      = $urandom & 32'hFFFF_FFFC;
            ImmOp      = (32'($urandom_range(0, 63)) - 32'd32) << 2;
            if ($urandom_range(0, 15) == 0) ImmOp = ImmOp + 32'd2;
            if (drought == 0 && $urandom_range(0, 399) == 0) drought = TIMEOUT + 4;
            if (drought > 0) begin
                drought--;
                imem_ack = 1'b0;
            end else if (m_req) begin
                imem_ack = ($urandom_range(0, 1) == 0);
            end else begin
                imem_ack = ($urandom_range(0, 7) == 0);
            end
            imem_rdata = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
